// File: rtl/synth_pkg.sv
// Shared synth-engine types: voice/tuning widths, the DDS pipeline-state codes
// and the tuning-update record carried from the SPI decoder to the DDS.
package synth_pkg;

   localparam int VOICE_W  = 8;
   localparam int TUNING_W = 32;

   localparam logic [1:0] PS_READ    = 2'd0;
   localparam logic [1:0] PS_COMPUTE = 2'd1;
   localparam logic [1:0] PS_UPDATE  = 2'd2;
   localparam logic [1:0] PS_IDLE    = 2'd3;

   // Encodings equal the pipeline-state codes so the state register drives the DDS directly.
   typedef enum logic [1:0] {
      ST_S0   = PS_READ,
      ST_S1   = PS_COMPUTE,
      ST_S2   = PS_UPDATE,
      ST_IDLE = PS_IDLE
   } sched_state_t;

   typedef struct packed {
      logic [VOICE_W-1:0]  voice;
      logic [TUNING_W-1:0] tuning;
   } upd_entry_t;

endpackage

// File: rtl/tuning_update_fifo.sv
// Tuning-update FIFO with registered ready and a look-ahead head for the releaser.
// Define VOICE_SCHED_COALESCE_EN to merge a push into a queued entry for the same voice.
module tuning_update_fifo
   import synth_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_push_valid,
   input  upd_entry_t                i_push_entry,
   input  logic                      i_pop,
   output logic                      o_ready,
   output logic [$clog2(DEPTH):0]    o_level,
   output logic [$clog2(DEPTH):0]    o_level_next,
   output upd_entry_t                o_head_next
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   upd_entry_t    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_next, waddr, match_idx;
   logic [LW-1:0] level;
   logic          ready_q, accept, alloc, match;

   assign accept = i_push_valid && ready_q;

`ifdef VOICE_SCHED_COALESCE_EN
   // The head being popped this cycle is leaving, so it never absorbs a push.
   always_comb begin
      logic [AW-1:0] off;
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      match     = 1'b0;
      match_idx = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rd_ptr;
         if (!match && ({1'b0, off} < level) && !(i_pop && (AW'(i) == rd_ptr))
             && (mem[i].voice == i_push_entry.voice)) begin
            match     = 1'b1;
            match_idx = AW'(i);
         end
      end
   end
`else
   assign match     = 1'b0;
   assign match_idx = '0;
`endif

   assign alloc        = accept && !match;
   assign waddr        = match ? match_idx : wr_ptr;
   assign rd_ptr_next  = rd_ptr + AW'(i_pop);
   assign o_level_next = level + LW'(alloc) - LW'(i_pop);
   assign o_head_next  = (accept && (waddr == rd_ptr_next)) ? i_push_entry : mem[rd_ptr_next];
   assign o_level      = level;
   assign o_ready      = ready_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level   <= '0;
         ready_q <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         rd_ptr  <= rd_ptr_next;
         if (alloc) wr_ptr <= wr_ptr + AW'(1);
         level   <= o_level_next;
         ready_q <= (o_level_next != LW'(DEPTH));
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and level define which entries are live.
   always_ff @(posedge i_clk) begin
      if (accept) mem[waddr] <= i_push_entry;
   end

endmodule

// File: rtl/voice_scheduler.sv
// Per-sample voice sequencer for the DDS pipeline plus one-per-slot tuning-update release.
// Optional VOICE_SCHED_COALESCE_EN enables same-voice update merging in the FIFO.
module voice_scheduler
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 64,
   parameter int SAMPLE_DIV = 1042,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic                          i_upd_valid,
   input  logic [TUNING_W-1:0]           i_upd_tuning,
   input  logic [VOICE_W-1:0]            i_upd_voice,
   output logic                          o_upd_ready,
   output logic [VOICE_W-1:0]            o_voice_index,
   output logic [1:0]                    o_pipeline_state,
   output logic                          o_dds_flag,
   output logic [TUNING_W-1:0]           o_dds_tuning,
   output logic [VOICE_W-1:0]            o_dds_voice,
   output logic                          o_phase_strobe,
   output logic                          o_frame_start,
   output logic                          o_frame_done,
   output logic                          o_overrun,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int LW    = $clog2(FIFO_DEPTH) + 1;

   logic [DIV_W-1:0]   div_cnt;
   logic               tick, last_slot, release_next;
   sched_state_t       state, state_next;
   logic [VOICE_W-1:0] voice, voice_next;
   logic [LW-1:0]      level_next;
   upd_entry_t         push_entry, head_next;

   assign tick      = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign last_slot = (state == ST_S2) && (voice == VOICE_W'(NUM_VOICES - 1));

   always_comb begin
      state_next = state;
      voice_next = voice;
      unique case (state)
         ST_IDLE: if (tick && i_enable) begin
            state_next = ST_S0;
            voice_next = '0;
         end
         ST_S0:   state_next = ST_S1;
         ST_S1:   state_next = ST_S2;
         ST_S2:   if (last_slot) begin
            state_next = ST_IDLE;
         end else begin
            state_next = ST_S0;
            voice_next = voice + VOICE_W'(1);
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The release decision is made one cycle early so the strobe is a flop that rises with S0.
   assign release_next = (state_next == ST_S0) && (level_next != '0);
   assign push_entry   = '{voice: i_upd_voice, tuning: i_upd_tuning};

   tuning_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_push_valid (i_upd_valid),
      .i_push_entry (push_entry),
      .i_pop        (o_dds_flag),
      .o_ready      (o_upd_ready),
      .o_level      (o_fifo_level),
      .o_level_next (level_next),
      .o_head_next  (head_next)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         div_cnt        <= '0;
         state          <= ST_IDLE;
         voice          <= '0;
         o_frame_start  <= 1'b0;
         o_frame_done   <= 1'b0;
         o_phase_strobe <= 1'b0;
         o_overrun      <= 1'b0;
         o_dds_flag     <= 1'b0;
         o_dds_tuning   <= '0;
         o_dds_voice    <= '0;
      end else begin
         div_cnt        <= tick ? '0 : div_cnt + DIV_W'(1);
         state          <= state_next;
         voice          <= voice_next;
         o_frame_start  <= (state == ST_IDLE) && (state_next == ST_S0);
         o_frame_done   <= last_slot;
         o_phase_strobe <= (state_next == ST_S2);
         o_overrun      <= o_overrun || (tick && (state != ST_IDLE));
         o_dds_flag     <= release_next;
         if (release_next) begin
            o_dds_tuning <= head_next.tuning;
            o_dds_voice  <= head_next.voice;
         end
      end
   end

   assign o_voice_index    = voice;
   assign o_pipeline_state = state;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: frame timing, overrun, FIFO release order,
// coalescing (follows VOICE_SCHED_COALESCE_EN), enable drop and mid-frame reset.
module tb_voice_scheduler;

   localparam int NV    = 4;
   localparam int DIV   = 20;
   localparam int DIVOV = 10;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_tuning = '0;
   logic [7:0]  upd_voice = '0;

   logic        upd_ready, dds_flag, phase_strobe, frame_start, frame_done, overrun;
   logic [7:0]  voice_index, dds_voice;
   logic [1:0]  pstate;
   logic [31:0] dds_tuning;
   logic [2:0]  fifo_level;

   logic        ov_upd_ready, ov_dds_flag, ov_phase_strobe, ov_frame_start, ov_frame_done, ov_overrun;
   logic [7:0]  ov_voice_index, ov_dds_voice;
   logic [1:0]  ov_pstate;
   logic [31:0] ov_dds_tuning;
   logic [2:0]  ov_fifo_level;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_reset(rst), .i_enable(enable),
      .i_upd_valid(upd_valid), .i_upd_tuning(upd_tuning), .i_upd_voice(upd_voice),
      .o_upd_ready(upd_ready), .o_voice_index(voice_index), .o_pipeline_state(pstate),
      .o_dds_flag(dds_flag), .o_dds_tuning(dds_tuning), .o_dds_voice(dds_voice),
      .o_phase_strobe(phase_strobe), .o_frame_start(frame_start), .o_frame_done(frame_done),
      .o_overrun(overrun), .o_fifo_level(fifo_level)
   );

   voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_DIV(DIVOV), .FIFO_DEPTH(DEPTH)) dut_ov (
      .i_clk(clk), .i_reset(rst), .i_enable(1'b1),
      .i_upd_valid(1'b0), .i_upd_tuning(32'h0), .i_upd_voice(8'h0),
      .o_upd_ready(ov_upd_ready), .o_voice_index(ov_voice_index), .o_pipeline_state(ov_pstate),
      .o_dds_flag(ov_dds_flag), .o_dds_tuning(ov_dds_tuning), .o_dds_voice(ov_dds_voice),
      .o_phase_strobe(ov_phase_strobe), .o_frame_start(ov_frame_start), .o_frame_done(ov_frame_done),
      .o_overrun(ov_overrun), .o_fifo_level(ov_fifo_level)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Outputs are sampled on the falling edge; cycle n is the n-th cycle after reset release.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".state"},  pstate,       2'd3);
      check({tag, ".voice"},  voice_index,  8'd0);
      check({tag, ".ovr"},    overrun,      1'b0);
      check({tag, ".level"},  fifo_level,   3'd0);
      check({tag, ".ready"},  upd_ready,    1'b1);
      check({tag, ".flag"},   dds_flag,     1'b0);
      check({tag, ".tuning"}, dds_tuning,   32'h0);
      check({tag, ".dvoice"}, dds_voice,    8'h0);
      check({tag, ".strobes"}, {phase_strobe, frame_start, frame_done}, 3'b000);
   endtask

   // Assumes the caller is at a falling edge; holds reset for two cycles.
   task automatic apply_reset(input string tag);
      upd_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_vals(tag);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic push(input logic [7:0] v, input logic [31:0] t);
      upd_valid  = 1'b1;
      upd_voice  = v;
      upd_tuning = t;
   endtask

   // Position within a frame starting at s0 or s1 (12 cycles each), else -1.
   function automatic int frame_pos(input int c, input int s0, input int s1);
      if (c >= s0 && c < s0 + 3 * NV) return c - s0;
      if (c >= s1 && c < s1 + 3 * NV) return c - s1;
      return -1;
   endfunction

   task automatic check_frame(input string tag, input int c, input int s0, input int s1,
                              input logic [1:0] st, input logic [7:0] vi,
                              input logic fs, input logic fd, input logic ps);
      int k;
      logic [1:0] e_st;
      logic [7:0] e_vi;
      k    = frame_pos(c, s0, s1);
      e_st = (k >= 0) ? 2'(k % 3) : 2'd3;
      e_vi = (k >= 0) ? 8'(k / 3) : ((c < s0) ? 8'd0 : 8'(NV - 1));
      check({tag, ".state"}, st, e_st);
      check({tag, ".voice"}, vi, e_vi);
      check({tag, ".fstart"}, fs, (k == 0));
      check({tag, ".fdone"}, fd, (c == s0 + 3 * NV) || (c == s1 + 3 * NV));
      check({tag, ".pstrobe"}, ps, (k >= 0) && (k % 3 == 2));
   endtask

   initial begin
      @(negedge clk);

      // Frame timing (DIV 20) and overrun (DIV 10) side by side.
      apply_reset("rst0");
      enable = 1'b1;
      while (cyc <= 45) begin
         check_frame("seq", cyc, 20, 40, pstate, voice_index, frame_start, frame_done, phase_strobe);
         check("seq.ovr", overrun, 1'b0);
         check_frame("ov", cyc, 10, 30, ov_pstate, ov_voice_index, ov_frame_start, ov_frame_done, ov_phase_strobe);
         check("ov.ovr", ov_overrun, (cyc >= 20));
         step();
      end

      // Five back-to-back pushes into a 4-deep FIFO, then one release per S0.
      apply_reset("rst1");
      enable = 1'b1;
      while (cyc <= 33) begin
         if (cyc < 5) begin
            check("fifo.ready", upd_ready, (cyc < 4));
            push(8'(10 + cyc), 32'hA000_0000 + 32'(cyc));
         end else begin
            upd_valid = 1'b0;
         end
         if (cyc == 5)  check("fifo.level_full", fifo_level, 3'd4);
         if (cyc == 21) check("fifo.level_pop1", fifo_level, 3'd3);
         if (cyc == 30) check("fifo.level_empty", fifo_level, 3'd0);
         check("fifo.flag", dds_flag, (cyc == 20 || cyc == 23 || cyc == 26 || cyc == 29));
         if (cyc == 20 || cyc == 23 || cyc == 26 || cyc == 29) begin
            check("fifo.dvoice", dds_voice, 8'(10 + (cyc - 20) / 3));
            check("fifo.tuning", dds_tuning, 32'hA000_0000 + 32'((cyc - 20) / 3));
         end
         step();
      end

      // Two pushes to the same voice with the FIFO otherwise idle.
      apply_reset("rst2");
      enable = 1'b1;
      while (cyc <= 24) begin
         upd_valid = 1'b0;
         if (cyc == 2) push(8'd7, 32'h1000);
         if (cyc == 3) push(8'd7, 32'h2000);
`ifdef VOICE_SCHED_COALESCE_EN
         if (cyc == 4 || cyc == 19) check("coal.level", fifo_level, 3'd1);
         if (cyc == 20) check("coal.tuning0", dds_tuning, 32'h2000);
         if (cyc == 23) check("coal.flag1", dds_flag, 1'b0);
`else
         if (cyc == 4 || cyc == 19) check("coal.level", fifo_level, 3'd2);
         if (cyc == 20) check("coal.tuning0", dds_tuning, 32'h1000);
         if (cyc == 23) check("coal.flag1", dds_flag, 1'b1);
         if (cyc == 23) check("coal.tuning1", dds_tuning, 32'h2000);
`endif
         if (cyc == 20) check("coal.flag0", dds_flag, 1'b1);
         if (cyc == 20) check("coal.dvoice", dds_voice, 8'd7);
         step();
      end

      // Enable dropped mid-frame: frame finishes, no new frame, pushes still accepted.
      apply_reset("rst3");
      enable = 1'b1;
      while (cyc <= 60) begin
         upd_valid = 1'b0;
         if (cyc == 25) enable = 1'b0;
         if (cyc == 31) check("en.state31", {pstate, voice_index}, {2'd2, 8'd3});
         if (cyc == 32) check("en.done", {frame_done, pstate}, {1'b1, 2'd3});
         if (cyc == 40) check("en.nostart", {frame_start, pstate}, {1'b0, 2'd3});
         if (cyc == 60) check("en.idle60", pstate, 2'd3);
         if (cyc >= 40 && cyc <= 43) begin
            check("en.ready", upd_ready, 1'b1);
            push(8'(20 + cyc - 40), 32'h5000 + 32'(cyc));
         end
         if (cyc == 44) check("en.full", {upd_ready, fifo_level}, {1'b0, 3'd4});
         if (cyc >= 40) check("en.noflag", dds_flag, 1'b0);
         step();
      end

      // Reset during S1 of voice 2, then restart on the next tick.
      apply_reset("rst4");
      enable = 1'b1;
      while (cyc <= 27) begin
         upd_valid = 1'b0;
         if (cyc == 1) push(8'd1, 32'h11);
         if (cyc == 2) push(8'd2, 32'h22);
         if (cyc == 20) check("mid.rel", {dds_flag, dds_tuning}, {1'b1, 32'h11});
         if (cyc == 27) check("mid.pos", {pstate, voice_index}, {2'd1, 8'd2});
         if (cyc < 27) step();
         else break;
      end
      apply_reset("mid.rst");
      while (cyc <= 20) begin
         if (cyc == 19) check("mid.idle19", pstate, 2'd3);
         if (cyc == 20) begin
            check("mid.restart", {pstate, voice_index, frame_start}, {2'd0, 8'd0, 1'b1});
            check("mid.empty", {dds_flag, fifo_level}, {1'b0, 3'd0});
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Sequencer and update arbiter for the per-voice DDS phase engine. Once per sample tick it walks every voice through the three-cycle DDS pipeline (read, compute, update) by driving voice index and pipeline state. It buffers incoming SPI tuning writes in a small FIFO and releases at most one per voice slot, so the DDS single-entry update buffer is never overrun. It sits between the SPI decoder and the DDS, and its frame strobes drive the downstream wavetable and mixer.

## Interface
- NUM_VOICES, 64, voices per frame (1..256)
- SAMPLE_DIV, 1042, clock cycles per sample tick; must be ≥ 3*NUM_VOICES+1
- FIFO_DEPTH, 4, tuning-update FIFO entries (power of 2, ≥ 2)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  high: frames start on ticks; low: current frame completes, then idle
- i_upd_valid  in  1  tuning-update request
- i_upd_tuning  in  32  delta-phase tuning code
- i_upd_voice  in  8  target voice index
- o_upd_ready  out  1  FIFO not full; a push occurs only when valid && ready
- o_voice_index  out  8  voice index to the DDS
- o_pipeline_state  out  2  0 read, 1 compute, 2 update, 3 idle (no DDS action)
- o_dds_flag  out  1  one-cycle update strobe to the DDS
- o_dds_tuning  out  32  tuning code, valid with o_dds_flag
- o_dds_voice  out  8  voice index, valid with o_dds_flag
- o_phase_strobe  out  1  DDS phase output valid for o_voice_index
- o_frame_start  out  1  pulse on the first S0 of a frame
- o_frame_done  out  1  pulse on the cycle after the last S2
- o_overrun  out  1  sticky: a tick arrived while a frame was in progress
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Divider counts 0..SAMPLE_DIV-1 and wraps. A tick fires when the count equals SAMPLE_DIV-1.
- FSM states: IDLE, S0, S1, S2.
  - IDLE: a tick with i_enable=1 moves to S0 with voice 0.
  - S0 → S1 → S2.
  - S2: if voice < NUM_VOICES-1, increment voice and go to S0; otherwise go to IDLE.
- o_pipeline_state encodes the state directly: S0=0, S1=1, S2=2, IDLE=3. o_voice_index holds the current voice and holds its last value in IDLE.
- Tick outside IDLE: the tick is dropped, o_overrun is set, and the frame continues. o_overrun clears only on reset.
- i_enable is sampled only in IDLE. Deasserting it mid-frame does not shorten the frame.
- o_phase_strobe = (state == S2).
- Update release:
  - In S0 with the FIFO non-empty: pop the head onto o_dds_tuning/o_dds_voice and pulse o_dds_flag for that cycle. This yields at most one release per voice slot.
  - No release in IDLE, S1 or S2.
- Push: accepted when i_upd_valid && o_upd_ready. A push and a pop may occur in the same cycle. o_upd_ready = !full; a push while full is refused even if a pop occurs that cycle.
- Empty FIFO with a push in the same S0 cycle: no release that cycle. The entry waits for the next S0.
- FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH.

## Timing
- All outputs are registered.
- Reset values:
  - o_voice_index 0, o_pipeline_state 3, o_overrun 0, o_fifo_level 0, o_upd_ready 1
  - all strobes 0, o_dds_tuning and o_dds_voice 0
  - divider 0, FSM in IDLE
- Tick in cycle T → S0 for voice 0 and o_frame_start in cycle T+1.
- A frame occupies 3*NUM_VOICES cycles. o_frame_done and o_pipeline_state=3 appear in cycle T+1+3*NUM_VOICES.
- Push in cycle P: o_fifo_level updates in P+1, and the entry is eligible for release from P+1 onward.
- Reset mid-frame: all state returns to reset values immediately, FIFO contents are discarded, and no partial strobes are produced.

## Configuration
- VOICE_SCHED_COALESCE_EN defined:
  - A push whose voice matches an entry already in the FIFO overwrites that entry's tuning code in place. No new entry is allocated and the level is unchanged.
  - Exception: an entry being popped in the same cycle is not a match, so the push allocates a new entry.
  - o_upd_ready stays !full; a coalescing push while full is still refused.
- VOICE_SCHED_COALESCE_EN undefined: every accepted push allocates an entry.

## Structure
- Shared package synth_pkg holds:
  - VOICE_W=8 and TUNING_W=32
  - pipeline-state constants PS_READ=0, PS_COMPUTE=1, PS_UPDATE=2, PS_IDLE=3, which the DDS also consumes
- Sub-module tuning_update_fifo contains the storage, pointers, level, and the coalesce match logic under VOICE_SCHED_COALESCE_EN.
- voice_scheduler contains the divider, the FSM, and the release logic.

## Test plan
- NUM_VOICES=4, SAMPLE_DIV=20: reset, then run → first tick at cycle 19, o_frame_start at 20, state sequence 0,1,2 for voices 0..3, o_frame_done at cycle 32, idle (state 3) until the next tick at cycle 39.
- SAMPLE_DIV=10, NUM_VOICES=4 → the second tick lands mid-frame: o_overrun=1 and stays 1, the frame still completes all 12 cycles, and the next frame starts on the following tick seen in IDLE.
- Push 5 updates back-to-back, FIFO_DEPTH=4 → 4 accepted, o_upd_ready=0 on the 5th; releases occur one per S0 in push order, with o_dds_voice and o_dds_tuning matching.
- Push voice 7/0x1000 then voice 7/0x2000 with the FIFO idle → coalesce defined: level 1, one release with 0x2000; undefined: level 2, releases 0x1000 then 0x2000.
- i_enable dropped in the middle of a frame → the frame finishes and no further frames start; pushes still accepted until full.
- Assert i_reset during S1 of voice 2 → outputs at reset values in the same cycle, FIFO empty, restart on the first tick after release.
